// File: rtl/wdt_pkg.sv
// Shared types and default constants for the watchdog service agent.
//   agent_state_t : agent FSM states
//   *_DEF         : default values for the agent parameters
package wdt_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARMED        = 3'd1,
    SERVICE      = 3'd2,
    RECOVER_KICK = 3'd3,
    ESCALATE     = 3'd4
  } agent_state_t;

  localparam int unsigned MIN_GAP_DEF         = 4;
  localparam int unsigned RECOVER_TIMEOUT_DEF = 64;
  localparam int unsigned INTR_LIMIT_DEF      = 3;
  localparam int unsigned CNT_WIDTH_DEF       = 8;

endpackage

// File: rtl/wdt_kick_gen.sv
// Rate-limited kick generator for the watchdog flag input.
// Heartbeats latch a pending request; the request turns into a one-cycle
// kick once at least MIN_GAP cycles separate it from the previous kick.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   heartbeat      : activity pulse from the monitored logic
//   allow          : heartbeats may be latched and turned into kicks
//   force_kick     : unconditional kick (recovery completion)
//   clear_pending  : drop any latched heartbeat request
//   kick           : registered one-cycle kick pulse
//   hb_kick        : a heartbeat-driven kick is being issued at this edge
module wdt_kick_gen
  import wdt_pkg::*;
#(
  parameter int unsigned MIN_GAP = MIN_GAP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic heartbeat,
  input  logic allow,
  input  logic force_kick,
  input  logic clear_pending,
  output logic kick,
  output logic hb_kick
);

  localparam int GAP_W = ($clog2(MIN_GAP + 1) > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

  logic             pending;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_inc;

  function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] g);
    return (g >= GAP_MAX) ? GAP_MAX : g + 1'b1;
  endfunction

  // The gap test uses the post-increment value so consecutive kicks land
  // exactly MIN_GAP cycles apart when heartbeats are continuous.
  assign gap_inc = gap_sat_inc(gap);
  assign hb_kick = allow && pending && (gap_inc >= GAP_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      gap     <= GAP_MAX;
      kick    <= 1'b0;
    end else begin
      kick <= hb_kick || force_kick;
      gap  <= (hb_kick || force_kick) ? '0 : gap_inc;
      // Heartbeats arriving while a request is latched collapse into it.
      if (clear_pending || hb_kick)
        pending <= 1'b0;
      else if (allow && heartbeat)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/wdt_service_agent.sv
// Host-side watchdog service agent. Converts heartbeats into rate-limited
// kicks, answers watchdog interrupts with a recovery handshake, and raises a
// sticky escalation on recovery timeout or repeated interrupts.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : agent enable; low returns to IDLE (except from ESCALATE)
//   heartbeat     : activity pulse from the monitored logic
//   wdt_intr      : watchdog interrupt level; rising edge is the event
//   recover_done  : recovery completion pulse
//   kick          : one-cycle pulse to the watchdog flag input
//   recover_req   : recovery request level
//   escalate      : sticky fault, cleared only by rst
//   intr_count    : saturating count of interrupt events
module wdt_service_agent
  import wdt_pkg::*;
#(
  parameter int unsigned MIN_GAP         = MIN_GAP_DEF,
  parameter int unsigned RECOVER_TIMEOUT = RECOVER_TIMEOUT_DEF,
  parameter int unsigned INTR_LIMIT      = INTR_LIMIT_DEF,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 heartbeat,
  input  logic                 wdt_intr,
  input  logic                 recover_done,
  output logic                 kick,
  output logic                 recover_req,
  output logic                 escalate,
  output logic [CNT_WIDTH-1:0] intr_count
);

  localparam int TMO_W    = (RECOVER_TIMEOUT > 1) ? $clog2(RECOVER_TIMEOUT) : 1;
  localparam int CONSEC_W = ($clog2(INTR_LIMIT + 1) > 0) ? $clog2(INTR_LIMIT + 1) : 1;
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(RECOVER_TIMEOUT - 1);
  localparam logic [CONSEC_W-1:0] CONSEC_LIM = CONSEC_W'(INTR_LIMIT);

  agent_state_t        state;
  logic                intr_prev;
  logic                intr_rise;
  logic [TMO_W-1:0]    tmo;
  logic [CONSEC_W-1:0] consec;
  logic [CONSEC_W-1:0] consec_next;
  logic                allow;
  logic                clear_pending;
  logic                force_kick;
  logic                hb_kick;

  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [CONSEC_W-1:0] consec_sat_inc(input logic [CONSEC_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign intr_rise   = wdt_intr && !intr_prev;
  assign consec_next = consec_sat_inc(consec);

  // An interrupt edge pre-empts any heartbeat kick decided on the same edge.
  assign allow         = (state == ARMED) && en && !intr_rise;
  assign clear_pending = !allow;
  assign force_kick    = (state == SERVICE) && en && recover_done;

  wdt_kick_gen #(
    .MIN_GAP (MIN_GAP)
  ) u_kick_gen (
    .clk           (clk),
    .rst           (rst),
    .heartbeat     (heartbeat),
    .allow         (allow),
    .force_kick    (force_kick),
    .clear_pending (clear_pending),
    .kick          (kick),
    .hb_kick       (hb_kick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      recover_req <= 1'b0;
      escalate    <= 1'b0;
      intr_count  <= '0;
      consec      <= '0;
      intr_prev   <= 1'b0;
      tmo         <= '0;
    end else begin
      intr_prev <= wdt_intr;
      case (state)
        IDLE: begin
          if (en) state <= ARMED;
        end
        ARMED: begin
          if (!en) begin
            state <= IDLE;
          end else if (intr_rise) begin
            intr_count <= cnt_sat_inc(intr_count);
            consec     <= consec_next;
            tmo        <= '0;
            if (consec_next == CONSEC_LIM) begin
              state    <= ESCALATE;
              escalate <= 1'b1;
            end else begin
              state       <= SERVICE;
              recover_req <= 1'b1;
            end
          end else if (hb_kick) begin
            consec <= '0;
          end
        end
        SERVICE: begin
          if (!en) begin
            state       <= IDLE;
            recover_req <= 1'b0;
          end else begin
            // Interrupts during recovery are only counted.
            if (intr_rise) intr_count <= cnt_sat_inc(intr_count);
            if (recover_done) begin
              state       <= RECOVER_KICK;
              recover_req <= 1'b0;
            end else if (tmo == TMO_LAST) begin
              state       <= ESCALATE;
              recover_req <= 1'b0;
              escalate    <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end
        RECOVER_KICK: begin
          // An edge landing in this single cycle is counted but starts no
          // new recovery; the edge register already holds it high.
          if (en && intr_rise) intr_count <= cnt_sat_inc(intr_count);
          state <= en ? ARMED : IDLE;
        end
        ESCALATE: begin
          state <= ESCALATE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
